// File: rtl/redun_mont_pkg.sv
// rtl/redun_mont_pkg.sv - shared redundant Montgomery types, modulus and encode/decode helpers
package redun_mont_pkg;

  localparam int NUM_WRDS = 16;
  localparam int WRD_BITS = 16;
  localparam int BIN_BITS = NUM_WRDS * WRD_BITS;

  typedef logic [NUM_WRDS-1:0][WRD_BITS:0] redun0_t;
  typedef logic [BIN_BITS-1:0]             bin_t;

  // Modulus 2^256 - 189
  localparam bin_t P = {{(BIN_BITS-8){1'b1}}, 8'h43};

  // Binary to redundant form with every carry bit cleared
  function automatic redun0_t to_redun(input bin_t b);
    redun0_t r;
    for (int i = 0; i < NUM_WRDS; i++) begin
      r[i] = {1'b0, b[i*WRD_BITS +: WRD_BITS]};
    end
    return r;
  endfunction

  // Redundant form back to binary, truncated to BIN_BITS
  function automatic bin_t from_redun(input redun0_t r);
    bin_t acc;
    acc = '0;
    for (int i = 0; i < NUM_WRDS; i++) begin
      acc = acc + (bin_t'(r[i]) << (i * WRD_BITS));
    end
    return acc;
  endfunction

endpackage

// File: rtl/redun_to_bin_pkg.sv
// rtl/redun_to_bin_pkg.sv - converter state encoding (REDUN_TO_BIN_FINAL_REDUCE_EN adds REDUCE)
package redun_to_bin_pkg;

`ifdef REDUN_TO_BIN_FINAL_REDUCE_EN
  typedef enum logic [1:0] {IDLE, CARRY, REDUCE, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, CARRY, DONE} state_t;
`endif

endpackage

// File: rtl/redun_to_bin_carry_slice.sv
// rtl/redun_to_bin_carry_slice.sv - combinational carry resolve of one slice of redundant words
module redun_carry_slice #(
  parameter int WRDS_PER_CYC = 4,
  parameter int WRD_BITS     = 16
) (
  input  logic [WRDS_PER_CYC-1:0][WRD_BITS:0]   wrds,
  input  logic [1:0]                            cin,
  output logic [WRDS_PER_CYC*WRD_BITS-1:0]      bits,
  output logic [1:0]                            cout
);

  // Ripple the carry word by word; carry never exceeds 2 so two bits suffice
  always_comb begin
    logic [1:0]          c;
    logic [WRD_BITS+1:0] s;
    c    = cin;
    s    = '0;
    bits = '0;
    for (int i = 0; i < WRDS_PER_CYC; i++) begin
      s = {1'b0, wrds[i]} + {{WRD_BITS{1'b0}}, c};
      bits[i*WRD_BITS +: WRD_BITS] = s[WRD_BITS-1:0];
      c = s[WRD_BITS+1:WRD_BITS];
    end
    cout = c;
  end

endmodule

// File: rtl/redun_to_bin.sv
// rtl/redun_to_bin.sv - word-serial redundant-to-binary converter (optional REDUN_TO_BIN_FINAL_REDUCE_EN)
module redun_to_bin
  import redun_to_bin_pkg::*;
#(
  parameter int NUM_WRDS     = redun_mont_pkg::NUM_WRDS,
  parameter int WRD_BITS     = redun_mont_pkg::WRD_BITS,
  parameter int WRDS_PER_CYC = 4
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic [NUM_WRDS-1:0][WRD_BITS:0]     i_dat,
  input  logic                                i_val,
  output logic                                o_rdy,
  output logic [NUM_WRDS*WRD_BITS-1:0]        o_dat,
  output logic                                o_ovf,
  output logic                                o_val,
  input  logic                                i_rdy
);

  localparam int NUM_SLC  = NUM_WRDS / WRDS_PER_CYC;
  localparam int SLC_BITS = WRDS_PER_CYC * WRD_BITS;
  localparam int CW       = (NUM_SLC > 1) ? $clog2(NUM_SLC) : 1;

  state_t                               state, state_nxt;
  logic [NUM_WRDS-1:0][WRD_BITS:0]      wrds;
  logic [1:0]                           carry;
  logic [CW-1:0]                        slc;
  logic                                 last_slc;
  logic [WRDS_PER_CYC-1:0][WRD_BITS:0]  slc_wrds;
  logic [SLC_BITS-1:0]                  slc_bits;
  logic [1:0]                           slc_cout;

  assign last_slc = (slc == CW'(NUM_SLC - 1));
  assign slc_wrds = wrds[slc*WRDS_PER_CYC +: WRDS_PER_CYC];

  redun_carry_slice #(
    .WRDS_PER_CYC (WRDS_PER_CYC),
    .WRD_BITS     (WRD_BITS)
  ) u_slice (
    .wrds (slc_wrds),
    .cin  (carry),
    .bits (slc_bits),
    .cout (slc_cout)
  );

`ifdef REDUN_TO_BIN_FINAL_REDUCE_EN
  localparam logic [NUM_WRDS*WRD_BITS-1:0] P_BIN = redun_mont_pkg::P;

  logic                          borrow;
  logic [NUM_WRDS*WRD_BITS-1:0]  d_reg;
  logic [SLC_BITS:0]             sub;

  // Slice of result - P, chained through the borrow register
  assign sub = {1'b0, slc_bits} - {1'b0, P_BIN[slc*SLC_BITS +: SLC_BITS]}
             - {{SLC_BITS{1'b0}}, borrow};
`endif

  // Next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    o_rdy     = 1'b0;
    o_val     = 1'b0;
    case (state)
      IDLE: begin
        o_rdy = 1'b1;
        if (i_val) state_nxt = CARRY;
      end
      CARRY: begin
`ifdef REDUN_TO_BIN_FINAL_REDUCE_EN
        if (last_slc) state_nxt = REDUCE;
`else
        if (last_slc) state_nxt = DONE;
`endif
      end
`ifdef REDUN_TO_BIN_FINAL_REDUCE_EN
      REDUCE: state_nxt = DONE;
`endif
      DONE: begin
        o_val = 1'b1;
        if (i_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register, operand capture and per-slice result accumulation
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      wrds  <= '0;
      carry <= '0;
      slc   <= '0;
      o_dat <= '0;
      o_ovf <= 1'b0;
`ifdef REDUN_TO_BIN_FINAL_REDUCE_EN
      borrow <= 1'b0;
      d_reg  <= '0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (i_val) begin
            wrds  <= i_dat;
            carry <= '0;
            slc   <= '0;
`ifdef REDUN_TO_BIN_FINAL_REDUCE_EN
            borrow <= 1'b0;
`endif
          end
        end
        CARRY: begin
          o_dat[slc*SLC_BITS +: SLC_BITS] <= slc_bits;
          carry <= slc_cout;
          slc   <= slc + 1'b1;
          if (last_slc) o_ovf <= (slc_cout != 2'd0);
`ifdef REDUN_TO_BIN_FINAL_REDUCE_EN
          d_reg[slc*SLC_BITS +: SLC_BITS] <= sub[SLC_BITS-1:0];
          borrow <= sub[SLC_BITS];
`endif
        end
`ifdef REDUN_TO_BIN_FINAL_REDUCE_EN
        // Result >= P (or overflowed past 2^N*W): take result - P
        REDUCE: begin
          if (o_ovf || !borrow) begin
            o_dat <= d_reg;
            o_ovf <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: doc/redun_to_bin.md
Name: redun_to_bin

Overview:
- Converts a redundant-form residue into plain binary. Input is NUM_WRDS words, each WRD_BITS+1 bits; output is NUM_WRDS*WRD_BITS bits.
- Sits at the output of the redundant Montgomery squarer.
- It is the decode direction of the to_redun encoding: it resolves the per-word carry bits by word-serial carry propagation, WRDS_PER_CYC words per cycle.
- Uses valid/ready handshakes on both sides so the host, DMA or checker can consume the result.

Parameters:
- NUM_WRDS, default redun_mont_pkg::NUM_WRDS: number of redundant words.
- WRD_BITS, default redun_mont_pkg::WRD_BITS: payload bits per word; redundant words carry one extra bit.
- WRDS_PER_CYC, default 4: words resolved per CARRY cycle. Must divide NUM_WRDS.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- i_dat  in  [WRD_BITS:0] x NUM_WRDS  redundant operand (redun0_t)
- i_val  in  1  input valid
- o_rdy  out  1  input ready; high only in IDLE
- o_dat  out  NUM_WRDS*WRD_BITS  binary result (bin_t)
- o_ovf  out  1  carry out of the top word
- o_val  out  1  output valid; held until accepted
- i_rdy  in  1  downstream ready

Behaviour:
- Reset values: o_dat=0, o_ovf=0, o_val=0, o_rdy=1, state=IDLE, carry register=0, slice counter=0.
- States: IDLE, CARRY, DONE.
- IDLE:
  - o_rdy=1.
  - On i_val, capture i_dat into an internal word array, clear carry and counter, go to CARRY.
- CARRY: each cycle processes words k*WRDS_PER_CYC .. k*WRDS_PER_CYC+WRDS_PER_CYC-1, where k is the slice counter.
  - Per word: s = word + carry (WRD_BITS+2 bits).
  - The low WRD_BITS of s go into o_dat at the matching bit position.
  - carry = s >> WRD_BITS. Carry is 2 bits wide; its maximum is 2, since (2^(W+1)-1)+2 >> W = 2.
  - The carry register persists across cycles.
- After the slice with k = NUM_WRDS/WRDS_PER_CYC-1:
  - o_ovf = (final carry != 0).
  - Go to DONE with o_val=1.
- DONE:
  - o_val=1; o_dat and o_ovf are stable.
  - On i_rdy, clear o_val and go to IDLE.
  - o_rdy stays 0 during DONE even when i_rdy is high that cycle; the next capture happens one cycle after acceptance.
- Latency: NUM_WRDS/WRDS_PER_CYC + 1 cycles from the capturing edge to o_val, with i_rdy held high.
- Throughput: one result per NUM_WRDS/WRDS_PER_CYC + 2 cycles.
- Boundary conditions:
  - i_val outside IDLE is ignored; the source must hold it until o_rdy.
  - All-zero input gives o_dat=0, o_ovf=0.
  - Carry ripples fully across slice boundaries; there is no speculative carry shortcut.
  - o_dat is updated slice-by-slice during CARRY but is only valid when o_val=1.
- i_rst mid-CARRY or mid-DONE: the block returns to reset values on the next edge and the pending result is dropped (no o_val).
- i_rst and i_val asserted together: reset wins.

Optional Feature:
- Macro: REDUN_TO_BIN_FINAL_REDUCE_EN.
- With the macro defined:
  - During CARRY, a parallel borrow chain computes d = result - P slice-by-slice, with a 1-bit borrow register.
  - P is redun_mont_pkg::P in binary.
  - At the end, if o_ovf=1 or the final borrow is 0, o_dat is replaced with d and o_ovf is forced to 0.
  - The replacement costs one extra DONE-entry cycle, so latency is NUM_WRDS/WRDS_PER_CYC + 2.
  - Output is then reduced to [0, 2P) -> [0, P), assuming the input is < 2P.
- Without the macro: no subtraction logic; raw result plus o_ovf; latency as above.

Decomposition:
- Additions to redun_mont_pkg:
  - typedef bin_t = logic [NUM_WRDS*WRD_BITS-1:0].
  - function from_redun(redun0_t) returning bin_t, the combinational golden model used by the testbench.
  - Existing redun0_t, P, to_redun are reused.
- Sub-module redun_carry_slice: combinational; WRDS_PER_CYC words plus 2-bit carry-in in; WRDS_PER_CYC*WRD_BITS bits plus 2-bit carry-out out. It is instantiated once and driven by a counter-indexed mux.

Test Plan:
- Single carry: word0=0x1_0000 (bit WRD_BITS set), all others 0 -> o_dat=1<<WRD_BITS, o_ovf=0, o_val exactly NUM_WRDS/WRDS_PER_CYC+1 cycles after capture.
- Full ripple: word0=0x1_0000, words 1..N-1=0x0_FFFF -> o_dat=0, o_ovf=1. This checks carry across every slice boundary.
- Max carry: all words=0x1_FFFF -> o_dat==from_redun(i_dat) mod 2^(N*W), and o_ovf matches; covers carry value 2.
- Backpressure: hold i_rdy=0 for 10 cycles in DONE -> o_val and o_dat stable, o_rdy=0, a second i_val is ignored; release i_rdy -> next operand captured one cycle later.
- Reset mid-CARRY: assert i_rst on the second CARRY cycle -> o_val stays 0, o_rdy=1 next cycle, a new operand converts correctly.
- With REDUN_TO_BIN_FINAL_REDUCE_EN: input to_redun(P+5) -> o_dat=5; to_redun(P-1) -> o_dat=P-1; to_redun(0) -> 0. Also 1000 random squarer outputs compared against from_redun(x) mod P.
